// File: rtl/fu_chain_loader.sv
// Streams configuration words MSB-first into a functional-unit program chain,
// pulling exactly enough words to fill CHAIN_LEN bits per load.
module fu_chain_loader #(
    parameter  int unsigned CHAIN_LEN = 16,
    parameter  int unsigned WORD_W    = 8,
    localparam int unsigned BL_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              cfg_valid_i,
    input  logic [WORD_W-1:0] cfg_data_i,
    output logic              cfg_ready_o,
    output logic              program_en_o,
    output logic              program_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [BL_W-1:0]   bits_left_o
);

    localparam int unsigned NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int unsigned WL_W   = $clog2(NWORDS + 1);
    localparam int unsigned WB_W   = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WB_W-1:0]   wbits_q, wbits_d;
    logic [WL_W-1:0]   wl_q, wl_d;
    logic              ready_q, ready_d;
    logic              en_q, en_d;
    logic              data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BL_W-1:0]   bl_q, bl_d;

    logic              accept_c;
    logic              take_c;
    logic [BL_W-1:0]   rem_c;
    logic [WB_W-1:0]   wbits_new_c;

    assign accept_c = cfg_valid_i && ready_q;

    // Bits still owed after the current cycle decide how much of a new word is used.
    always_comb begin
        rem_c = (state_q == S_SHIFT) ? bl_q - BL_W'(1) : bl_q;
        if (32'(rem_c) >= WORD_W) begin
            wbits_new_c = WB_W'(WORD_W - 1);
        end else begin
            wbits_new_c = WB_W'(32'(rem_c) - 32'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wbits_d = wbits_q;
        wl_d    = wl_q;
        ready_d = 1'b0;
        en_d    = 1'b0;
        data_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bl_d    = bl_q;
        take_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                bl_d   = '0;
                if (start_i && !abort_i) begin
                    state_d = S_LOAD;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
                    bl_d    = BL_W'(CHAIN_LEN);
                    wl_d    = WL_W'(NWORDS);
                end
            end
            S_LOAD: begin
                take_c  = accept_c;
                ready_d = !accept_c;
            end
            S_SHIFT: begin
                bl_d = bl_q - BL_W'(1);
                if (wbits_q != '0) begin
                    en_d    = 1'b1;
                    data_d  = word_q[WORD_W-1];
                    word_d  = {word_q[WORD_W-2:0], 1'b0};
                    wbits_d = wbits_q - WB_W'(1);
                    ready_d = (wbits_q == WB_W'(1)) && (wl_q != '0);
                end else if (bl_q == BL_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (accept_c) begin
                    take_c = 1'b1;
                end else begin
                    state_d = S_LOAD;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accepted word: its MSB goes out next cycle, the rest waits in word_q.
        if (take_c) begin
            state_d = S_SHIFT;
            en_d    = 1'b1;
            data_d  = cfg_data_i[WORD_W-1];
            word_d  = {cfg_data_i[WORD_W-2:0], 1'b0};
            wbits_d = wbits_new_c;
            wl_d    = wl_q - WL_W'(1);
            ready_d = (wbits_new_c == '0) && (wl_q != WL_W'(1));
        end

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            en_d    = 1'b0;
            data_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            bl_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bl_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            en_q    <= en_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bl_q    <= bl_d;
        end
    end

    // Datapath registers are always written before being observed.
    always_ff @(posedge clk_i) begin
        word_q  <= word_d;
        wbits_q <= wbits_d;
        wl_q    <= wl_d;
    end

    assign cfg_ready_o    = ready_q;
    assign program_en_o   = en_q;
    assign program_data_o = data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign bits_left_o    = bl_q;

endmodule

// File: tb/tb_fu_chain_loader.sv
// Bench for fu_chain_loader: directed cycle-exact scenarios plus random loads
// checked against a bit-count reference model.
module tb_fu_chain_loader;

    localparam int unsigned LA  = 12;
    localparam int unsigned LB  = 16;
    localparam int unsigned W   = 8;
    localparam int unsigned NWA = (LA + W - 1) / W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, valid;
    logic [7:0] data;

    logic       a_ready, a_en, a_data, a_busy, a_done;
    logic [3:0] a_bl;
    logic       b_ready, b_en, b_data, b_busy, b_done;
    logic [4:0] b_bl;
    logic [8:0] a_vec;
    logic [9:0] b_vec;

    int n_checks = 0;
    int n_pass   = 0;

    assign a_vec = {a_ready, a_en, a_data, a_busy, a_done, a_bl};
    assign b_vec = {b_ready, b_en, b_data, b_busy, b_done, b_bl};

    fu_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .cfg_valid_i(valid), .cfg_data_i(data),
        .cfg_ready_o(a_ready), .program_en_o(a_en), .program_data_o(a_data),
        .busy_o(a_busy), .done_o(a_done), .bits_left_o(a_bl)
    );

    fu_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .cfg_valid_i(valid), .cfg_data_i(data),
        .cfg_ready_o(b_ready), .program_en_o(b_en), .program_data_o(b_data),
        .busy_o(b_busy), .done_o(b_done), .bits_left_o(b_bl)
    );

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; valid = 1'b0; data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; abort = 1'b1; valid = 1'b1; data = 8'hFF;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (a_vec !== 9'd0) $display("FAIL reset_a c=%0d got=%b exp=0", c, a_vec);
            else n_pass++;
            n_checks++;
            if (b_vec !== 10'd0) $display("FAIL reset_b c=%0d got=%b exp=0", c, b_vec);
            else n_pass++;
            @(posedge clk);
        end
        #1 rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [11:0] pat = 12'hA53;
        int nen = 0;
        logic e_en, e_busy;
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            start = (c == 0); valid = 1'b1; data = (c <= 1) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            e_en   = (c >= 2 && c <= 13);
            e_busy = (c >= 1 && c <= 13);
            exp = {(c == 1 || c == 9), e_en, e_en ? pat[13-c] : 1'b0, e_busy, (c == 14),
                   e_busy ? 4'(12 - nen) : 4'd0};
            n_checks++;
            if (a_vec !== exp) $display("FAIL stream c=%0d got=%b exp=%b", c, a_vec, exp);
            else n_pass++;
            if (e_en) nen++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        logic [11:0] pat = 12'hA53;
        int nen = 0;
        logic e_en, e_busy, e_bit;
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 22; c++) begin
            start = (c == 0); valid = (c <= 1) || (c >= 15);
            data = (c <= 1) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            e_en   = (c >= 2 && c <= 9) || (c >= 16 && c <= 19);
            e_busy = (c >= 1 && c <= 19);
            e_bit  = !e_en ? 1'b0 : (c <= 9) ? pat[13-c] : pat[19-c];
            exp = {(c == 1 || (c >= 9 && c <= 15)), e_en, e_bit, e_busy, (c == 20),
                   e_busy ? 4'(12 - nen) : 4'd0};
            n_checks++;
            if (a_vec !== exp) $display("FAIL stall c=%0d got=%b exp=%b", c, a_vec, exp);
            else n_pass++;
            if (e_en) nen++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        logic [11:0] pat = 12'hA53;
        int nen = 0;
        logic e_en, e_busy, e_bit;
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            start = (c == 0 || c == 8); abort = (c == 5); valid = 1'b1;
            data = (c <= 9) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            e_en   = (c >= 2 && c <= 5) || (c >= 10 && c <= 21);
            e_busy = (c >= 1 && c <= 5) || (c >= 9 && c <= 21);
            e_bit  = !e_en ? 1'b0 : (c <= 5) ? pat[13-c] : pat[21-c];
            if (!e_busy) nen = 0;
            exp = {(c == 1 || c == 9 || c == 17), e_en, e_bit, e_busy, (c == 22),
                   e_busy ? 4'(12 - nen) : 4'd0};
            n_checks++;
            if (a_vec !== exp) $display("FAIL abort c=%0d got=%b exp=%b", c, a_vec, exp);
            else n_pass++;
            if (e_en) nen++;
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset_midload();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            rst = (c == 7); start = (c == 0 || c == 7); valid = 1'b1;
            data = (c <= 1) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            if (c >= 8) begin
                n_checks++;
                if (a_vec !== 9'd0) $display("FAIL reset_mid c=%0d got=%b exp=0", c, a_vec);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic test_corners();
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 21; c++) begin
            start = (c == 0 || c == 2 || c == 5); abort = (c == 0 || c == 3 || c == 18);
            valid = 1'b1; data = (c <= 6) ? 8'hA5 : 8'h3C;
            @(negedge clk);
            if (c == 1 || c == 2 || c == 4 || c == 19 || c == 7 || c == 18) begin
                exp = (c == 7) ? {5'b01110, 4'd12} : (c == 18) ? {5'b01110, 4'd1} : 9'd0;
                n_checks++;
                if (a_vec !== exp) $display("FAIL corners c=%0d got=%b exp=%b", c, a_vec, exp);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    task automatic test_exact_fit();
        int nen = 0;
        logic e_en, e_busy;
        logic [9:0] exp;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            start = (c == 0 || c == 5); valid = 1'b1;
            data = (c <= 1) ? 8'hFF : 8'h00;
            @(negedge clk);
            e_en   = (c >= 2 && c <= 17);
            e_busy = (c >= 1 && c <= 17);
            exp = {(c == 1 || c == 9), e_en, (e_en && c <= 9), e_busy, (c == 18),
                   e_busy ? 5'(16 - nen) : 5'd0};
            n_checks++;
            if (b_vec !== exp) $display("FAIL exact_fit c=%0d got=%b exp=%b", c, b_vec, exp);
            else n_pass++;
            if (e_en) nen++;
            @(posedge clk); #1;
        end
    endtask

    // Reference: tracks bits shifted and words taken per load, predicts each cycle.
    task automatic test_random();
        logic [7:0] words [NWA];
        logic [7:0] w;
        logic m_busy = 0, m_en = 0, m_done = 0, m_ready = 0;
        logic busy_n, en_n, done_n, e_bit;
        int m_k = 0, m_acc = 0, k_n, acc_n;
        logic [8:0] exp;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (!m_busy) for (int i = 0; i < NWA; i++) words[i] = 8'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 9) < 6);
            data  = valid ? words[(m_acc < NWA) ? m_acc : 0] : 8'($urandom);
            @(negedge clk);
            w = words[m_k / W];
            e_bit = m_en ? w[7 - (m_k % W)] : 1'b0;
            exp = {m_ready, m_en, e_bit, m_busy, m_done, m_busy ? 4'(LA - m_k) : 4'd0};
            n_checks++;
            if (a_vec !== exp) $display("FAIL random c=%0d got=%b exp=%b", c, a_vec, exp);
            else n_pass++;
            k_n = m_k + (m_en ? 1 : 0); acc_n = m_acc;
            busy_n = 0; en_n = 0; done_n = 0;
            if (rst || (m_busy && abort)) begin
                k_n = 0;
            end else if (!m_busy) begin
                busy_n = start && !abort; k_n = 0; acc_n = 0;
            end else if (m_en && k_n == LA) begin
                done_n = 1;
            end else begin
                busy_n = 1;
                if (valid && m_ready) begin
                    en_n = 1; acc_n = m_acc + 1;
                end else if (m_en && (k_n % W) != 0) begin
                    en_n = 1;
                end
            end
            m_ready = busy_n && (acc_n < NWA) && (!en_n || (k_n % W) == W - 1);
            m_busy = busy_n; m_en = en_n; m_done = done_n; m_k = k_n; m_acc = acc_n;
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = 8'h00;
        test_reset();
        test_stream();
        test_stall();
        test_abort();
        test_reset_midload();
        test_corners();
        test_exact_fit();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fu_chain_loader.md
FU_CHAIN_LOADER -- requirements
Module: fu_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 16, is the total program bits shifted into the downstream functional-unit chain per load; legal values are >= 1.
REQ-002 Parameter WORD_W, default 8, is the width of a configuration word; legal values are >= 2.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 start_i  input  1  begins a load when sampled high in IDLE.
REQ-006 abort_i  input  1  cancels an in-progress load.
REQ-007 cfg_valid_i  input  1  cfg_data_i holds a valid configuration word.
REQ-008 cfg_data_i  input  WORD_W  configuration word; MSB is shifted first.
REQ-009 cfg_ready_o  output  1  loader accepts cfg_data_i this cycle.
REQ-010 program_en_o  output  1  drives the chain's program_en_i.
REQ-011 program_data_o  output  1  drives the first slice's program_data_i.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 done_o  output  1  one-cycle pulse on completion of a load.
REQ-014 bits_left_o  output  $clog2(CHAIN_LEN+1)  program bits not yet shifted out.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD and SHIFT.
- IDLE->LOAD on start_i.
- LOAD->SHIFT on word accept.
- SHIFT->LOAD when the current word is exhausted and no new word is accepted while bits remain.
- SHIFT->IDLE after the final bit.
REQ-016 A word SHALL be accepted only in the cycle where cfg_valid_i && cfg_ready_o.
REQ-017 cfg_ready_o SHALL be high only while at least one more word is needed, and only when one of these holds:
- the state is LOAD;
- the state is SHIFT and the current shift cycle outputs the last bit of the current word.
REQ-018 Every output SHALL be a register output, with no combinational path from any input.
REQ-019 For a word accepted in cycle T, bit WORD_W-1 SHALL appear on program_data_o with program_en_o=1 in cycle T+1, and the following bits in T+2, T+3, and so on.
REQ-020 Back-to-back words SHALL stream with no bubble.
REQ-021 When no word is available after the current word is exhausted, program_en_o SHALL be 0 and program_data_o SHALL be 0 until a word is accepted (stall).
REQ-022 Exactly CHAIN_LEN cycles with program_en_o=1 SHALL occur per completed load.
REQ-023 The loader SHALL accept exactly ceil(CHAIN_LEN/WORD_W) words per load.
REQ-024 When CHAIN_LEN mod WORD_W != 0, only the upper (CHAIN_LEN mod WORD_W) bits of the final word SHALL be shifted; its lower bits SHALL be discarded.
REQ-025 bits_left_o SHALL load CHAIN_LEN on start, decrement by 1 in every program_en_o=1 cycle, and never wrap below 0.
REQ-026 done_o SHALL pulse high for exactly one cycle, in the cycle after the final program_en_o=1 cycle; the state is IDLE in that same cycle.
REQ-027 start_i SHALL be ignored outside IDLE.
REQ-028 If start_i and abort_i are both high in IDLE, abort_i SHALL win and the state SHALL stay in IDLE.
REQ-029 abort_i high in LOAD or SHIFT SHALL cause the following effects in the next cycle:
- state is IDLE;
- program_en_o=0 and cfg_ready_o=0;
- bits_left_o=0;
- no done_o pulse.
REQ-030 If abort_i coincides with a word handshake, the word SHALL be discarded.
REQ-031 If abort_i coincides with the final bit cycle, done_o SHALL NOT pulse.

Reset
REQ-032 While rst_i is high at a clock edge, the next state SHALL be IDLE and every output SHALL be 0 (cfg_ready_o, program_en_o, program_data_o, busy_o, done_o, bits_left_o).
REQ-033 rst_i SHALL take priority over start_i and abort_i.
REQ-034 rst_i asserted mid-load SHALL take effect in the next cycle with no further program_en_o=1 cycles and no done_o.
REQ-035 Internal data and shift registers need not be reset, provided no output depends on their value while in IDLE.

Verification
REQ-036 Streaming, CHAIN_LEN=12, WORD_W=8: start_i at cycle 0; cfg_valid_i held high with 0xA5 and then 0x3C.
- Words are accepted at cycles 1 and 9.
- program_en_o=1 in cycles 2-13 with bits 1,0,1,0,0,1,0,1,0,0,1,1.
- done_o is high in cycle 14 only.
REQ-037 Stall: same setup, but 0x3C is withheld until cycle 15.
- program_en_o=0 in cycles 10-15.
- Bits resume in cycles 16-19.
- done_o is high at cycle 20.
- bits_left_o holds 4 throughout the stall.
REQ-038 Abort: abort_i pulsed at cycle 5 of REQ-036.
- Cycle 6: busy_o=0, program_en_o=0, bits_left_o=0.
- done_o is never high.
- A new start_i at cycle 8 restarts cleanly with bits_left_o=12.
REQ-039 Reset mid-load: rst_i high at cycle 7 of REQ-036.
- All outputs are 0 from cycle 8.
- start_i during rst_i is ignored.
REQ-040 Exact fit, CHAIN_LEN=16, WORD_W=8: words 0xFF and 0x00.
- Exactly 16 program_en_o cycles: 8 ones, then 8 zeros.
- cfg_ready_o never rises for a third word.
- start_i asserted while busy_o=1 has no effect.
